// File: rtl/i2s_pkg.sv
// Shared I2S types: master TX frame/config/state, pad bundle and bit-select helper.
package i2s_pkg;

   localparam int unsigned I2S_MAX_WORD_W = 32;
   localparam int unsigned I2S_CLKDIV_W   = 16;
   localparam int unsigned I2S_CNT_W      = $clog2(I2S_MAX_WORD_W);

   typedef struct packed {
      logic [I2S_MAX_WORD_W-1:0] sd0_l;
      logic [I2S_MAX_WORD_W-1:0] sd0_r;
      logic [I2S_MAX_WORD_W-1:0] sd1_l;
      logic [I2S_MAX_WORD_W-1:0] sd1_r;
   } i2s_tx_frame_t;

   typedef struct packed {
      logic                    en;
      logic [I2S_CLKDIV_W-1:0] clkdiv;
      logic [I2S_CNT_W-1:0]    word_len;
      logic                    lsb_first;
      logic                    sd1_en;
   } i2s_tx_cfg_t;

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      LEFT,
      RIGHT
   } i2s_tx_state_e;

   typedef struct packed {
      logic master_sck;
      logic master_sck_oe;
      logic master_ws;
      logic master_ws_oe;
      logic master_sd0;
      logic master_sd1;
   } i2s_to_pad_t;

   // Bit cnt of a right-aligned word of length word_len+1, in the chosen order.
   function automatic logic word_bit(input logic [I2S_MAX_WORD_W-1:0] word,
                                     input logic [I2S_CNT_W-1:0]      cnt,
                                     input logic [I2S_CNT_W-1:0]      word_len,
                                     input logic                      lsb_first);
      logic [I2S_CNT_W-1:0] idx;
      idx = lsb_first ? cnt : (word_len - cnt);
      return word[idx];
   endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// SCK generator: divider 0..clkdiv toggles SCK; sck_fall flags the cycle SCK goes 1->0.
module i2s_clkgen #(
   parameter int unsigned CLKDIV_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [CLKDIV_W-1:0] clkdiv,
   output logic                sck,
   output logic                sck_fall
);

   logic [CLKDIV_W-1:0] div_q;
   logic                tc;

   assign tc       = (div_q == clkdiv);
   assign sck_fall = en & tc & sck;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
         sck   <= 1'b0;
      end else if (!en) begin
         div_q <= '0;
         sck   <= 1'b0;
      end else if (tc) begin
         div_q <= '0;
         sck   <= ~sck;
      end else begin
         div_q <= div_q + 1'b1;
      end
   end

endmodule

// File: rtl/i2s_master_tx.sv
// Clock-master I2S transmitter: one-frame buffer feeding two serial lanes, Philips framing.
//
// state | meaning
// IDLE  | disabled, everything cleared
// PRIME | WS held high until the first SCK fall, which sends the dummy LSB
// LEFT  | shifting the left word, WS low (goes high with the left LSB)
// RIGHT | shifting the right word, WS high (goes low with the right LSB)
module i2s_master_tx
   import i2s_pkg::*;
#(
   parameter int unsigned MAX_WORD_W = I2S_MAX_WORD_W,
   parameter int unsigned CLKDIV_W   = I2S_CLKDIV_W
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          cfg_en_i,
   input  logic [CLKDIV_W-1:0]           cfg_clkdiv_i,
   input  logic [$clog2(MAX_WORD_W)-1:0] cfg_word_len_i,
   input  logic                          cfg_lsb_first_i,
   input  logic                          cfg_sd1_en_i,
   input  logic                          frame_valid_i,
   output logic                          frame_ready_o,
   input  logic [MAX_WORD_W-1:0]         frame_sd0_l_i,
   input  logic [MAX_WORD_W-1:0]         frame_sd0_r_i,
   input  logic [MAX_WORD_W-1:0]         frame_sd1_l_i,
   input  logic [MAX_WORD_W-1:0]         frame_sd1_r_i,
   output logic                          master_sck_o,
   output logic                          master_sck_oe_o,
   output logic                          master_ws_o,
   output logic                          master_ws_oe_o,
   output logic                          master_sd0_o,
   output logic                          master_sd1_o,
   output logic                          underrun_o
);

   i2s_tx_cfg_t          cfg;
   i2s_tx_frame_t        frame_in;
   i2s_tx_frame_t        buf_q;
   i2s_tx_frame_t        cur_q;
   i2s_tx_frame_t        load_frame;
   i2s_tx_frame_t        src;
   i2s_tx_state_e        state_q;
   i2s_to_pad_t          pad;
   logic [I2S_CNT_W-1:0] bit_cnt_q;
   logic                 ready_q;
   logic                 underrun_q;
   logic                 sck_oe_q;
   logic                 ws_q;
   logic                 ws_oe_q;
   logic                 sd0_q;
   logic                 sd1_q;
   logic                 sck;
   logic                 shift;
   logic                 accept;
   logic                 first_bit;
   logic                 last_bit;
   logic                 sd0_bit;
   logic                 sd1_bit;

   assign cfg.en          = cfg_en_i;
   assign cfg.clkdiv      = cfg_clkdiv_i;
   assign cfg.word_len    = cfg_word_len_i;
   assign cfg.lsb_first   = cfg_lsb_first_i;
   assign cfg.sd1_en      = cfg_sd1_en_i;

   assign frame_in.sd0_l  = frame_sd0_l_i;
   assign frame_in.sd0_r  = frame_sd0_r_i;
   assign frame_in.sd1_l  = frame_sd1_l_i;
   assign frame_in.sd1_r  = frame_sd1_r_i;

   i2s_clkgen #(
      .CLKDIV_W (CLKDIV_W)
   ) u_clkgen (
      .clk      (clk_i),
      .rst      (rst_i),
      .en       (cfg.en),
      .clkdiv   (cfg.clkdiv),
      .sck      (sck),
      .sck_fall (shift)
   );

   assign accept     = frame_valid_i & ready_q;
   assign first_bit  = (state_q == LEFT) && (bit_cnt_q == '0);
   assign last_bit   = (bit_cnt_q == cfg.word_len);
   // ready_q doubles as "buffer empty"; an empty buffer at load time sends silence
   assign load_frame = ready_q ? i2s_tx_frame_t'('0) : buf_q;
   assign src        = first_bit ? load_frame : cur_q;

   always_comb begin
      sd0_bit = 1'b0;
      sd1_bit = 1'b0;
      if (state_q == LEFT) begin
         sd0_bit = word_bit(src.sd0_l, bit_cnt_q, cfg.word_len, cfg.lsb_first);
         sd1_bit = word_bit(src.sd1_l, bit_cnt_q, cfg.word_len, cfg.lsb_first);
      end else if (state_q == RIGHT) begin
         sd0_bit = word_bit(src.sd0_r, bit_cnt_q, cfg.word_len, cfg.lsb_first);
         sd1_bit = word_bit(src.sd1_r, bit_cnt_q, cfg.word_len, cfg.lsb_first);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         buf_q      <= '0;
         cur_q      <= '0;
         ready_q    <= 1'b1;
         underrun_q <= 1'b0;
         sck_oe_q   <= 1'b0;
         ws_q       <= 1'b0;
         ws_oe_q    <= 1'b0;
         sd0_q      <= 1'b0;
         sd1_q      <= 1'b0;
      end else if (!cfg.en) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         buf_q      <= '0;
         cur_q      <= '0;
         ready_q    <= 1'b1;
         underrun_q <= 1'b0;
         sck_oe_q   <= 1'b0;
         ws_q       <= 1'b0;
         ws_oe_q    <= 1'b0;
         sd0_q      <= 1'b0;
         sd1_q      <= 1'b0;
      end else begin
         underrun_q <= 1'b0;
         if (accept) begin
            buf_q   <= frame_in;
            ready_q <= 1'b0;
         end else if (shift && first_bit) begin
            ready_q <= 1'b1;
         end

         case (state_q)
            IDLE: begin
               state_q   <= PRIME;
               sck_oe_q  <= 1'b1;
               ws_oe_q   <= 1'b1;
               ws_q      <= 1'b1;
               bit_cnt_q <= cfg.word_len;
            end
            PRIME: begin
               if (shift) begin
                  state_q   <= LEFT;
                  ws_q      <= 1'b0;
                  sd0_q     <= 1'b0;
                  sd1_q     <= 1'b0;
                  bit_cnt_q <= '0;
               end
            end
            LEFT, RIGHT: begin
               if (shift) begin
                  sd0_q <= sd0_bit;
                  sd1_q <= sd1_bit & cfg.sd1_en;
                  if (first_bit) begin
                     cur_q      <= load_frame;
                     underrun_q <= ready_q;
                  end
                  // WS flips together with the last bit so it leads the next MSB by one SCK
                  if (last_bit) begin
                     bit_cnt_q <= '0;
                     ws_q      <= (state_q == LEFT);
                     state_q   <= (state_q == LEFT) ? RIGHT : LEFT;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign pad.master_sck    = sck;
   assign pad.master_sck_oe = sck_oe_q;
   assign pad.master_ws     = ws_q;
   assign pad.master_ws_oe  = ws_oe_q;
   assign pad.master_sd0    = sd0_q;
   assign pad.master_sd1    = sd1_q;

   assign master_sck_o    = pad.master_sck;
   assign master_sck_oe_o = pad.master_sck_oe;
   assign master_ws_o     = pad.master_ws;
   assign master_ws_oe_o  = pad.master_ws_oe;
   assign master_sd0_o    = pad.master_sd0;
   assign master_sd1_o    = pad.master_sd1;
   assign frame_ready_o   = ready_q;
   assign underrun_o      = underrun_q;

endmodule
